// File: rtl/aes256_decipher.sv
// ---------------------------------------------------------------------------
// aes256_decipher
//   Iterative AES-256 inverse cipher. A key load expands the 15 round keys
//   into a local bank, one keyExpansion step per cycle. Each ciphertext block
//   is then processed one round per clock. The result is held until the
//   downstream side accepts it.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   key[255:0]            cipher key, byte 0 in key[255:248]
//   key_valid/key_ready   key handshake (ready in IDLE or READY)
//   datain[127:0]         ciphertext, byte 0 in [127:120], column-major
//   in_valid/in_ready     ciphertext handshake (ready in READY only)
//   dataout[127:0]        plaintext, same byte order as datain
//   out_valid/out_ready   plaintext handshake
//   key_loaded            round-key bank holds a complete schedule
//
// The file also contains the leaf cells used here: gf_inv8, aes_sbox,
// inv_sbox and keyExpansion.
// ---------------------------------------------------------------------------
module aes256_decipher #(
    parameter int NR = 14
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [255:0] key,
    input  logic         key_valid,
    output logic         key_ready,
    input  logic [127:0] datain,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [127:0] dataout,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         key_loaded
);

    typedef enum logic [2:0] {IDLE, KEXP, READY, ROUND, DONE} state_t;

    state_t         state_q, state_d;
    logic [127:0]   rk_q [0:NR];
    logic [127:0]   rk_d [0:NR];
    logic [255:0]   work_q, work_d;
    logic [2:0]     step_q, step_d;
    logic [127:0]   s_q, s_d;
    logic [3:0]     r_q, r_d;

    logic [255:0]   ke_out;
    logic [3:0]     kidx_lo, kidx_hi;
    logic [127:0]   isr, isb, ark, imc;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        // Row n of column c comes from column (c - n) mod 4.
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8 * (4 * c + r) -: 8] = s[127 - 8 * (4 * ((c + 4 - r) % 4) + r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [31:0] inv_mix_column(input logic [31:0] col);
        logic [7:0] a [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] x2, x4, x8;
        for (int i = 0; i < 4; i++) begin
            a[i]  = col[31 - 8 * i -: 8];
            x2    = xtime(a[i]);
            x4    = xtime(x2);
            x8    = xtime(x4);
            m9[i] = x8 ^ a[i];
            mb[i] = x8 ^ x2 ^ a[i];
            md[i] = x8 ^ x4 ^ a[i];
            me[i] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++) begin
            o[127 - 32 * c -: 32] = inv_mix_column(s[127 - 32 * c -: 32]);
        end
        return o;
    endfunction

    // Round datapath: InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns
    assign isr = inv_shift_rows(s_q);

    for (genvar g = 0; g < 16; g++) begin : g_isb
        inv_sbox u_inv_sbox (
            .a (isr[127 - 8 * g -: 8]),
            .y (isb[127 - 8 * g -: 8])
        );
    end

    assign ark = isb ^ rk_q[r_q];
    assign imc = inv_mix_columns(ark);

    keyExpansion u_key_expansion (
        .rc      ({1'b0, step_q}),
        .key_in  (work_q),
        .key_out (ke_out)
    );

    // Step i = step_q + 1 writes rk[2i] and rk[2i+1].
    assign kidx_lo = {step_q, 1'b0} + 4'd2;
    assign kidx_hi = {step_q, 1'b1} + 4'd2;

    always_comb begin
        state_d = state_q;
        rk_d    = rk_q;
        work_d  = work_q;
        step_d  = step_q;
        s_d     = s_q;
        r_d     = r_q;
        case (state_q)
            IDLE, READY: begin
                if (key_valid) begin
                    rk_d[0] = key[255:128];
                    rk_d[1] = key[127:0];
                    work_d  = key;
                    step_d  = '0;
                    state_d = KEXP;
                end else if (state_q == READY && in_valid) begin
                    s_d     = datain ^ rk_q[NR];
                    r_d     = 4'(NR - 1);
                    state_d = ROUND;
                end
            end
            KEXP: begin
                rk_d[kidx_lo] = ke_out[255:128];
                // The final step only needs the upper half (rk[14]).
                if (step_q != 3'd6) begin
                    rk_d[kidx_hi] = ke_out[127:0];
                end
                work_d = ke_out;
                step_d = step_q + 3'd1;
                if (step_q == 3'd6) begin
                    state_d = READY;
                end
            end
            ROUND: begin
                if (r_q != 4'd0) begin
                    s_d = imc;
                    r_d = r_q - 4'd1;
                end else begin
                    // Last round has no InvMixColumns.
                    s_d     = ark;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = READY;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            work_q  <= '0;
            step_q  <= '0;
            s_q     <= '0;
            r_q     <= '0;
            for (int i = 0; i <= NR; i++) begin
                rk_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            step_q  <= step_d;
            s_q     <= s_d;
            r_q     <= r_d;
            for (int i = 0; i <= NR; i++) begin
                rk_q[i] <= rk_d[i];
            end
        end
    end

    assign key_ready  = (state_q == IDLE) || (state_q == READY);
    assign in_ready   = (state_q == READY) && !key_valid;
    assign out_valid  = (state_q == DONE);
    assign dataout    = s_q;
    assign key_loaded = (state_q == READY) || (state_q == ROUND) || (state_q == DONE);

endmodule

// ---------------------------------------------------------------------------
// gf_inv8: multiplicative inverse in GF(2^8), poly 0x11b, computed as a^254.
//   a  input byte;  y  inverse (0 maps to 0)
// ---------------------------------------------------------------------------
module gf_inv8 (
    input  logic [7:0] a,
    output logic [7:0] y
);
    function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] b);
        logic [7:0] p, t;
        p = '0;
        t = x;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252;

    always_comb begin
        x2   = gmul(a, a);
        x3   = gmul(x2, a);
        x6   = gmul(x3, x3);
        x12  = gmul(x6, x6);
        x15  = gmul(x12, x3);
        x30  = gmul(x15, x15);
        x60  = gmul(x30, x30);
        x120 = gmul(x60, x60);
        x240 = gmul(x120, x120);
        x252 = gmul(x240, x12);
        y    = gmul(x252, x2);
    end
endmodule

// ---------------------------------------------------------------------------
// aes_sbox: forward AES S-box (inverse followed by affine map).
//   a  input byte;  y  substituted byte
// ---------------------------------------------------------------------------
module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    logic [7:0] inv;

    gf_inv8 u_inv (.a(a), .y(inv));

    assign y = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
endmodule

// ---------------------------------------------------------------------------
// inv_sbox: inverse AES S-box (inverse affine map followed by inverse).
//   a  input byte;  y  substituted byte
// ---------------------------------------------------------------------------
module inv_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    logic [7:0] t;

    assign t = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;

    gf_inv8 u_inv (.a(t), .y(y));
endmodule

// ---------------------------------------------------------------------------
// keyExpansion: one AES-256 schedule step, eight new words from eight old.
//   rc       round-constant index (Rcon = 0x01 << rc)
//   key_in   previous eight words w[i..i+7]
//   key_out  next eight words w[i+8..i+15]
// ---------------------------------------------------------------------------
module keyExpansion (
    input  logic [3:0]   rc,
    input  logic [255:0] key_in,
    output logic [255:0] key_out
);
    logic [31:0] rot, sw1, sw2;
    logic [31:0] n0, n1, n2, n3, n4, n5, n6, n7;
    logic [7:0]  rcon;

    assign rcon = 8'h01 << rc;
    assign rot  = {key_in[23:0], key_in[31:24]};

    for (genvar g = 0; g < 4; g++) begin : g_sub
        aes_sbox u_s1 (.a(rot[31 - 8 * g -: 8]), .y(sw1[31 - 8 * g -: 8]));
        aes_sbox u_s2 (.a(n3[31 - 8 * g -: 8]),  .y(sw2[31 - 8 * g -: 8]));
    end

    assign n0 = key_in[255:224] ^ sw1 ^ {rcon, 24'h0};
    assign n1 = key_in[223:192] ^ n0;
    assign n2 = key_in[191:160] ^ n1;
    assign n3 = key_in[159:128] ^ n2;
    // AES-256 applies SubWord without rotation half-way through each step.
    assign n4 = key_in[127:96]  ^ sw2;
    assign n5 = key_in[95:64]   ^ n4;
    assign n6 = key_in[63:32]   ^ n5;
    assign n7 = key_in[31:0]    ^ n6;

    assign key_out = {n0, n1, n2, n3, n4, n5, n6, n7};
endmodule
